lc3_regfile_sb: RTL and testbench
=================================

# lc3_regfile_sb

Parametrised, scoreboarded register file for the pipelined LC-3 datapath. It provides two asynchronous read ports and one synchronous write port, with same-cycle write-to-read bypass and per-register busy bits for in-order hazard detection. It also holds the NZP condition-code register. It sits between decode (reads and reserves) and writeback (writes and releases), and moves DR/SR selection muxing out to the decoder.

## Interface
Parameters:
- WIDTH, 16, data width in bits.
- NREGS, 8, number of architectural registers; power of two, at least 2.
- AW, $clog2(NREGS), register address width (derived; not overridden).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- rd1_addr, rd2_addr  in  AW  read addresses.
- rd1_data, rd2_data  out  WIDTH  read data, combinational.
- rd1_busy, rd2_busy  out  1  the addressed register has an outstanding producer that is not resolved this cycle.
- rsv_vld  in  1  reserve request: mark rsv_addr busy.
- rsv_addr  in  AW  register to reserve.
- wr_en  in  1  writeback valid.
- wr_addr  in  AW  writeback destination.
- wr_data  in  WIDTH  writeback data.
- wr_setcc  in  1  update NZP from wr_data; ignored unless wr_en=1.
- flush  in  1  synchronous clear of all busy bits.
- nzp  out  3  condition codes {N,Z,P}.
- busy_any  out  1  OR of all busy bits (registered state only).

## Operation
- Storage: regs[NREGS] of WIDTH, busy[NREGS], nzp_q[3].
- Reset (rst=0, asynchronous): all regs=0, all busy=0, nzp=3'b010 (Z). Combinational outputs follow from this state: rdN_data=0, rdN_busy=0, busy_any=0.
- Read: rdN_data = wr_data if wr_en and wr_addr==rdN_addr; otherwise regs[rdN_addr].
- Busy flag: rdN_busy = busy[rdN_addr] and not (wr_en and wr_addr==rdN_addr). A write in flight resolves the hazard in the same cycle.
- Write: on an edge with wr_en=1, regs[wr_addr] ← wr_data and busy[wr_addr] ← 0, unless overridden below.
- Reserve: on an edge with rsv_vld=1, busy[rsv_addr] ← 1. Reserving a register that is already busy is legal (in-order WAW); it stays busy.
- Priority for busy[i] at each edge, highest first: flush (→0), rsv_vld to i (→1), wr_en to i (→0), hold.
  - Simultaneous reserve and write to the same register: data is written and busy ends at 1, because the new producer owns it.
  - flush together with wr_en: the write still updates regs and nzp; all busy bits end at 0.
  - flush together with rsv_vld: the reservation is dropped.
- NZP: on an edge with wr_en and wr_setcc both 1: N = wr_data[WIDTH-1]; Z = (wr_data==0); P = neither. Exactly one bit is ever set.
- No register is hardwired to zero; all NREGS registers are writable.

## Timing
- Read latency 0: combinational from the address and from the bypass inputs.
- Write, reserve, flush and NZP updates become visible one edge after they are sampled.
- busy_any reflects registered busy bits only; it has no bypass term.
- Reset may assert mid-operation (during pending reservations or a write). The state clears immediately and asynchronously. The first edge after rst deasserts is treated as normal.
- rd*_busy depends combinationally on the wr_* inputs. wr_* must come from registers in the writeback stage.

## Structure
- Shared package lc3_pkg holds the NZP bit indices (NZP_N=2, NZP_Z=1, NZP_P=0) and the reset constant NZP_RESET=3'b010.
- Sub-module lc3_scoreboard, parametrised by NREGS, holds the busy vector, its priority logic, busy_any, and the per-port busy lookups.
- The top level holds the data array, the bypass muxes and nzp_q.

## Test plan
- Reset: hold rst=0 → all reads return 16'h0000, nzp=3'b010, busy_any=0. Write regs[1]=16'h1234 with rst=0 → not stored.
- Write then read: write R3=16'hBEEF, then read rd1_addr=3 on the next cycle → 16'hBEEF. In the write cycle itself, rd2_addr=3 returns 16'hBEEF via bypass.
- Scoreboard: reserve R5 → next cycle rd1_busy=1 and busy_any=1. In the cycle wr_en to R5 with 16'h0042 is applied: rd1_busy=0 and rd1_data=16'h0042. After that edge, busy[5]=0.
- Same-cycle reserve and write to R2 with 16'h0007 → R2=16'h0007 and busy[2]=1 afterwards.
- Flush: reserve R1, R4 and R7, then assert flush together with rsv_vld to R0 → busy_any=0 next cycle, and R0 is not busy.
- NZP with wr_setcc=1: write 16'h8000 → nzp=100; write 0 → 010; write 16'h7FFF → 001. A write with wr_setcc=0 leaves nzp unchanged.

Source files
------------

// File: rtl/lc3_pkg.sv
// lc3_pkg: constants and helpers shared by the LC-3 register-file slice.
//   NZP_N / NZP_Z / NZP_P : bit positions inside the {N,Z,P} condition-code vector
//   NZP_RESET            : condition-code value after reset (Z set)
//   nzp_encode()         : builds the one-hot {N,Z,P} code from sign and zero flags
package lc3_pkg;

  localparam int NZP_N = 2;
  localparam int NZP_Z = 1;
  localparam int NZP_P = 0;

  localparam logic [2:0] NZP_RESET = 3'b010;

  // Zero wins over sign so that exactly one bit is set for every input.
  function automatic logic [2:0] nzp_encode(input logic sign, input logic is_zero);
    logic [2:0] code;
    code = 3'b000;
    if (is_zero) begin
      code[NZP_Z] = 1'b1;
    end else if (sign) begin
      code[NZP_N] = 1'b1;
    end else begin
      code[NZP_P] = 1'b1;
    end
    return code;
  endfunction

endpackage

// File: rtl/lc3_scoreboard.sv
// lc3_scoreboard: per-register busy bits for in-order hazard detection.
//   clk, rst            : clock, asynchronous active-low reset
//   rsv_vld, rsv_addr   : reserve request (decode marks a destination busy)
//   wr_en, wr_addr      : writeback releases its destination
//   flush               : synchronous clear of every busy bit
//   rd1_addr, rd2_addr  : registers being looked up by the read ports
//   rd1_busy, rd2_busy  : lookup result, masked by a same-cycle writeback
//   busy_any            : OR of the registered busy bits (no bypass)
module lc3_scoreboard
  import lc3_pkg::*;
#(
  parameter  int NREGS = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rsv_vld,
  input  logic [AW-1:0] rsv_addr,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic          flush,
  input  logic [AW-1:0] rd1_addr,
  input  logic [AW-1:0] rd2_addr,
  output logic          rd1_busy,
  output logic          rd2_busy,
  output logic          busy_any
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Next busy state: flush beats reserve, reserve beats release, else hold.
  // Reserve beating release lets a new producer claim a register in the
  // same cycle its previous producer writes back.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NREGS; i++) begin
      if (flush) begin
        busy_d[i] = 1'b0;
      end else if (rsv_vld && (rsv_addr == AW'(i))) begin
        busy_d[i] = 1'b1;
      end else if (wr_en && (wr_addr == AW'(i))) begin
        busy_d[i] = 1'b0;
      end else begin
        busy_d[i] = busy_q[i];
      end
    end
  end

  // Busy-vector storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // A writeback in flight to the looked-up register resolves its hazard now.
  always_comb begin
    rd1_busy = busy_q[rd1_addr] && !(wr_en && (wr_addr == rd1_addr));
    rd2_busy = busy_q[rd2_addr] && !(wr_en && (wr_addr == rd2_addr));
    busy_any = |busy_q;
  end

endmodule

// File: rtl/lc3_regfile_sb.sv
// lc3_regfile_sb: scoreboarded LC-3 register file with NZP condition codes.
//   clk, rst                      : clock, asynchronous active-low reset
//   rd1_addr/rd2_addr             : read addresses
//   rd1_data/rd2_data             : combinational read data with write bypass
//   rd1_busy/rd2_busy             : addressed register has an unresolved producer
//   rsv_vld, rsv_addr             : reserve a destination register
//   wr_en, wr_addr, wr_data       : writeback port
//   wr_setcc                      : update NZP from wr_data (only with wr_en)
//   flush                         : clear all busy bits
//   nzp                           : condition codes {N,Z,P}
//   busy_any                      : any register busy (registered state only)
module lc3_regfile_sb
  import lc3_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int NREGS = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rd1_addr,
  input  logic [AW-1:0]    rd2_addr,
  output logic [WIDTH-1:0] rd1_data,
  output logic [WIDTH-1:0] rd2_data,
  output logic             rd1_busy,
  output logic             rd2_busy,
  input  logic             rsv_vld,
  input  logic [AW-1:0]    rsv_addr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_setcc,
  input  logic             flush,
  output logic [2:0]       nzp,
  output logic             busy_any
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [2:0]       nzp_q;
  logic [2:0]       nzp_d;

  lc3_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .rsv_vld  (rsv_vld),
    .rsv_addr (rsv_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .flush    (flush),
    .rd1_addr (rd1_addr),
    .rd2_addr (rd2_addr),
    .rd1_busy (rd1_busy),
    .rd2_busy (rd2_busy),
    .busy_any (busy_any)
  );

  // Data array: flush does not suppress a write, only the busy release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Condition codes follow the written value only when setcc accompanies a write.
  always_comb begin
    if (wr_en && wr_setcc) begin
      nzp_d = nzp_encode(wr_data[WIDTH-1], (wr_data == '0));
    end else begin
      nzp_d = nzp_q;
    end
  end

  // Condition-code register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nzp_q <= NZP_RESET;
    end else begin
      nzp_q <= nzp_d;
    end
  end

  // Read ports with same-cycle writeback bypass.
  always_comb begin
    if (wr_en && (wr_addr == rd1_addr)) begin
      rd1_data = wr_data;
    end else begin
      rd1_data = regs_q[rd1_addr];
    end
    if (wr_en && (wr_addr == rd2_addr)) begin
      rd2_data = wr_data;
    end else begin
      rd2_data = regs_q[rd2_addr];
    end
  end

  assign nzp = nzp_q;

endmodule

// File: tb/tb_lc3_regfile_sb.sv
// tb_lc3_regfile_sb: directed test-plan scenarios plus randomized traffic,
// checked against an array-based reference model of the register file.
module tb_lc3_regfile_sb;

  localparam int W = 16;
  localparam int N = 8;
  localparam int A = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [A-1:0] rd1_addr, rd2_addr, rsv_addr, wr_addr;
  logic [W-1:0] rd1_data, rd2_data, wr_data;
  logic         rd1_busy, rd2_busy, rsv_vld, wr_en, wr_setcc, flush;
  logic [2:0]   nzp;
  logic         busy_any;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [W-1:0] m_regs [N];
  logic         m_busy [N];
  logic [2:0]   m_nzp;

  lc3_regfile_sb #(.WIDTH(W), .NREGS(N)) dut (
    .clk(clk), .rst(rst),
    .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
    .rd1_data(rd1_data), .rd2_data(rd2_data),
    .rd1_busy(rd1_busy), .rd2_busy(rd2_busy),
    .rsv_vld(rsv_vld), .rsv_addr(rsv_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_setcc(wr_setcc),
    .flush(flush), .nzp(nzp), .busy_any(busy_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_nzp = 3'b010;
  endtask

  // Apply one clock edge to the model: write, then reserve, then flush.
  task automatic model_clock();
    if (wr_en) begin
      m_regs[wr_addr] = wr_data;
      m_busy[wr_addr] = 1'b0;
      if (wr_setcc) begin
        if (wr_data == 16'h0000)       m_nzp = 3'b010;
        else if ($signed(wr_data) < 0) m_nzp = 3'b100;
        else                           m_nzp = 3'b001;
      end
    end
    if (rsv_vld) m_busy[rsv_addr] = 1'b1;
    if (flush) begin
      for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    logic [W-1:0] e1, e2;
    logic         b1, b2, any;
    e1  = (wr_en && wr_addr == rd1_addr) ? wr_data : m_regs[rd1_addr];
    e2  = (wr_en && wr_addr == rd2_addr) ? wr_data : m_regs[rd2_addr];
    b1  = m_busy[rd1_addr] && !(wr_en && wr_addr == rd1_addr);
    b2  = m_busy[rd2_addr] && !(wr_en && wr_addr == rd2_addr);
    any = 1'b0;
    for (int i = 0; i < N; i++) any = any | m_busy[i];
    check({tag, ".rd1_data"}, rd1_data, e1);
    check({tag, ".rd2_data"}, rd2_data, e2);
    check({tag, ".rd1_busy"}, rd1_busy, b1);
    check({tag, ".rd2_busy"}, rd2_busy, b2);
    check({tag, ".busy_any"}, busy_any, any);
    check({tag, ".nzp"}, nzp, m_nzp);
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_setcc = 1'b0;
    rsv_vld = 1'b0; rsv_addr = '0; flush = 1'b0;
  endtask

  // Inputs are already driven; check combinational outputs, then take one edge.
  task automatic tick(input string tag);
    #1;
    check_model(tag);
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic do_write(input logic [A-1:0] a, input logic [W-1:0] d, input logic cc);
    idle(); wr_en = 1'b1; wr_addr = a; wr_data = d; wr_setcc = cc;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    rd1_addr = 3'd1; rd2_addr = 3'd3;
    model_reset();

    // reset holds: a write during reset is not stored
    #2;
    do_write(3'd1, 16'h1234, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    idle();
    #1;
    check("rst.rd1_data", rd1_data, 16'h0000);
    check("rst.nzp", nzp, 3'b010);
    check("rst.busy_any", busy_any, 1'b0);
    check_model("rst");
    rst = 1'b1;

    // write R3 then read, with same-cycle bypass on rd2
    do_write(3'd3, 16'hBEEF, 1'b0); rd2_addr = 3'd3;
    #1; check("bypass.rd2", rd2_data, 16'hBEEF);
    tick("wr_r3");
    idle(); rd1_addr = 3'd3;
    #1; check("read.r3", rd1_data, 16'hBEEF);
    tick("rd_r3");

    // reserve R5, then resolve it with a write
    idle(); rsv_vld = 1'b1; rsv_addr = 3'd5; rd1_addr = 3'd5;
    tick("rsv_r5");
    idle();
    #1; check("sb.rd1_busy", rd1_busy, 1'b1); check("sb.busy_any", busy_any, 1'b1);
    tick("r5_busy");
    do_write(3'd5, 16'h0042, 1'b0);
    #1; check("sb.resolve_busy", rd1_busy, 1'b0); check("sb.resolve_data", rd1_data, 16'h0042);
    tick("wr_r5");
    idle();
    #1; check("sb.released", rd1_busy, 1'b0);
    tick("r5_free");

    // same-cycle reserve and write R2: data written, stays busy
    do_write(3'd2, 16'h0007, 1'b0); rsv_vld = 1'b1; rsv_addr = 3'd2;
    tick("rsv_wr_r2");
    idle(); rd1_addr = 3'd2;
    #1; check("rsvwr.data", rd1_data, 16'h0007); check("rsvwr.busy", rd1_busy, 1'b1);
    tick("r2_busy");

    // flush with a concurrent reservation of R0
    foreach (m_busy[i]) if (i == 1 || i == 4 || i == 7) begin
      idle(); rsv_vld = 1'b1; rsv_addr = A'(i);
      tick("rsv_multi");
    end
    idle(); flush = 1'b1; rsv_vld = 1'b1; rsv_addr = 3'd0;
    tick("flush");
    idle(); rd1_addr = 3'd0;
    #1; check("flush.busy_any", busy_any, 1'b0); check("flush.r0", rd1_busy, 1'b0);
    tick("post_flush");

    // condition codes
    do_write(3'd6, 16'h8000, 1'b1); tick("cc_neg");
    idle(); #1; check("nzp.neg", nzp, 3'b100);
    do_write(3'd6, 16'h0000, 1'b1); tick("cc_zero");
    idle(); #1; check("nzp.zero", nzp, 3'b010);
    do_write(3'd6, 16'h7FFF, 1'b1); tick("cc_pos");
    idle(); #1; check("nzp.pos", nzp, 3'b001);
    do_write(3'd6, 16'h8000, 1'b0); tick("cc_nosetcc");
    idle(); #1; check("nzp.hold", nzp, 3'b001);

    // randomized traffic, with an occasional mid-operation reset
    for (int c = 0; c < 400; c++) begin
      wr_en    = ($urandom_range(0, 99) < 50);
      wr_addr  = A'($urandom_range(0, N-1));
      case ($urandom_range(0, 3))
        0:       wr_data = 16'h0000;
        1:       wr_data = 16'h8000 | W'($urandom_range(0, 16'h7FFF));
        default: wr_data = W'($urandom);
      endcase
      wr_setcc = ($urandom_range(0, 1) == 1);
      rsv_vld  = ($urandom_range(0, 99) < 40);
      rsv_addr = ($urandom_range(0, 1) == 1) ? wr_addr : A'($urandom_range(0, N-1));
      flush    = ($urandom_range(0, 99) < 5);
      rd1_addr = ($urandom_range(0, 2) == 0) ? wr_addr : A'($urandom_range(0, N-1));
      rd2_addr = A'($urandom_range(0, N-1));
      if (c % 97 == 50) begin
        rst = 1'b0;
        model_reset();
        #1; check_model("rand_rst");
        @(posedge clk); #1;
        rst = 1'b1;
      end else begin
        tick("rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
